// File: rtl/rocc_unit_pkg.sv
// Shared types for the RoCC execute-side responder: scoreboard-facing
// operand/exception records, the accelerator command/response records and
// the pending-operation FIFO entry.
package rocc_unit_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  // Exception cause reported when the accelerator flags a fault.
  localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            xd;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            error;
  } rocc_resp_t;

  // One in-flight operation: its scoreboard tag and whether a response is due.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic                     xd;
  } pending_t;

endpackage

// File: rtl/rocc_pending_fifo.sv
// In-order FIFO of issued-but-unretired operations. Besides the usual
// occupancy it keeps a running count of entries that still expect a
// response, so a flush knows how many stale responses to swallow.
module rocc_pending_fifo
  import rocc_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  pending_t               data_i,
  input  logic                   pop_i,
  output pending_t               data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] xd_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pending_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, xd_cnt_q;

  // Entry storage, written at the tail on every accepted push.
  // NOTE: the array has no reset; an entry is only read while count_q says it is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and counters; a flush empties the FIFO, pointers wrap naturally.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      xd_cnt_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      xd_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      count_q  <= count_q + CW'(push_i) - CW'(pop_i);
      xd_cnt_q <= xd_cnt_q + CW'(push_i && data_i.xd) - CW'(pop_i && data_o.xd);
    end
  end

  assign data_o   = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign xd_cnt_o = xd_cnt_q;

endmodule

// File: rtl/rocc_unit.sv
// RoCC responder in the execute stage: registers each issued operation as a
// command to the accelerator, tracks it in order, and writes results back to
// the scoreboard. After a flush, responses still owed for squashed operations
// are drained through drop_cnt_q before any new operation can match one.
module rocc_unit
  import rocc_unit_pkg::*;
#(
  parameter int unsigned NR_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     rocc_valid_i,
  input  logic [6:0]               rocc_funct7_i,
  input  logic [4:0]               rocc_rd_i,
  output logic                     rocc_ready_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [6:0]               cmd_funct7_o,
  output logic [4:0]               cmd_rd_o,
  output logic                     cmd_xd_o,
  output logic [XLEN-1:0]          cmd_rs1_o,
  output logic [XLEN-1:0]          cmd_rs2_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [XLEN-1:0]          resp_data_i,
  input  logic                     resp_error_i,
  output logic [TRANS_ID_BITS-1:0] rocc_trans_id_o,
  output logic [XLEN-1:0]          rocc_result_o,
  output exception_t               rocc_exception_o,
  output logic                     rocc_wb_valid_o
);

  localparam int unsigned CW = $clog2(NR_OUTSTANDING) + 1;
  localparam int unsigned DW = $clog2(NR_OUTSTANDING + 1) + 1;

  rocc_cmd_t                cmd_q, cmd_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic [TRANS_ID_BITS-1:0] cmd_tid_q, cmd_tid_d;
  logic [DW-1:0]            drop_cnt_q, drop_cnt_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [TRANS_ID_BITS-1:0] wb_tid_q, wb_tid_d;
  logic [XLEN-1:0]          wb_result_q, wb_result_d;
  exception_t               wb_exc_q, wb_exc_d;

  pending_t                 head;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count, fifo_xd_cnt;
  rocc_resp_t               resp;
  logic                     cmd_fire, issue, draining, drop_take, pop;

  assign resp     = '{data: resp_data_i, error: resp_error_i};
  assign cmd_fire = cmd_valid_q && cmd_ready_i;
  assign issue    = rocc_valid_i && rocc_ready_o;
  assign draining = (drop_cnt_q != '0);

  // The register frees up in the cycle it hands off; the FIFO slot for the
  // command it holds is reserved by counting that command as occupancy.
  assign rocc_ready_o = (!cmd_valid_q || cmd_fire)
                     && (({1'b0, fifo_count} + (CW+1)'(cmd_valid_q)) < (CW+1)'(NR_OUTSTANDING))
                     && !flush_i;

  // Stale responses take priority; a head with xd=0 needs no response at all.
  assign resp_ready_o = draining || fifo_empty || head.xd;
  assign drop_take    = draining && resp_valid_i;
  assign pop          = !fifo_empty && (!head.xd || (resp_valid_i && !draining));

  rocc_pending_fifo #(
    .DEPTH (NR_OUTSTANDING)
  ) i_pending_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .push_i   (cmd_fire),
    .data_i   ('{trans_id: cmd_tid_q, xd: cmd_q.xd}),
    .pop_i    (pop),
    .data_o   (head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count),
    .xd_cnt_o (fifo_xd_cnt)
  );

  // Command register: load on issue, clear on handoff or flush.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    cmd_tid_d   = cmd_tid_q;
    if (cmd_fire) begin
      cmd_valid_d = 1'b0;
    end
    if (issue) begin
      cmd_valid_d = 1'b1;
      cmd_d       = '{funct7: rocc_funct7_i, rd: rocc_rd_i, xd: (rocc_rd_i != '0),
                      rs1: fu_data_i.operand_a, rs2: fu_data_i.operand_b};
      cmd_tid_d   = fu_data_i.trans_id;
    end
    if (flush_i) begin
      cmd_valid_d = 1'b0;
    end
  end

  // Drop counter: a flush adds every response still owed, minus one the head
  // consumed this cycle, plus one for a command sent during the flush.
  always_comb begin
    drop_cnt_d = drop_cnt_q - DW'(drop_take);
    if (flush_i) begin
      drop_cnt_d = drop_cnt_d + DW'(fifo_xd_cnt) - DW'(pop && head.xd)
                 + DW'(cmd_fire && cmd_q.xd);
    end
  end

  // Writeback staging: capture the retiring head; a flush suppresses the strobe.
  always_comb begin
    wb_valid_d  = pop && !flush_i;
    wb_tid_d    = wb_tid_q;
    wb_result_d = wb_result_q;
    wb_exc_d    = wb_exc_q;
    if (pop) begin
      wb_tid_d    = head.trans_id;
      wb_result_d = head.xd ? resp.data : '0;
      wb_exc_d    = '0;
      if (head.xd && resp.error) begin
        wb_exc_d.valid = 1'b1;
        wb_exc_d.cause = ILLEGAL_INSTR;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_tid_q   <= '0;
      drop_cnt_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_tid_q    <= '0;
      wb_result_q <= '0;
      wb_exc_q    <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_tid_q   <= cmd_tid_d;
      drop_cnt_q  <= drop_cnt_d;
      wb_valid_q  <= wb_valid_d;
      wb_tid_q    <= wb_tid_d;
      wb_result_q <= wb_result_d;
      wb_exc_q    <= wb_exc_d;
    end
  end

  assign cmd_valid_o      = cmd_valid_q;
  assign cmd_funct7_o     = cmd_q.funct7;
  assign cmd_rd_o         = cmd_q.rd;
  assign cmd_xd_o         = cmd_q.xd;
  assign cmd_rs1_o        = cmd_q.rs1;
  assign cmd_rs2_o        = cmd_q.rs2;
  assign rocc_trans_id_o  = wb_tid_q;
  assign rocc_result_o    = wb_result_q;
  assign rocc_exception_o = wb_exc_q;
  assign rocc_wb_valid_o  = wb_valid_q;

  // A response with nothing pending and nothing to drain points at an accelerator bug.
  stray_resp_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(resp_valid_i && !draining && fifo_empty))
    else $warning("rocc_unit: response with no pending operation");

endmodule

// File: tb/tb_rocc_unit.sv
// Directed bench for rocc_unit: a table of single operations checked end to
// end, then hand-written sequences for backpressure, flush draining and
// reset while operations are pending.
module tb_rocc_unit;
  import rocc_unit_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     flush_i = 1'b0;
  fu_data_t                 fu_data_i = '0;
  logic                     rocc_valid_i = 1'b0;
  logic [6:0]               rocc_funct7_i = '0;
  logic [4:0]               rocc_rd_i = '0;
  logic                     rocc_ready_o;
  logic                     cmd_valid_o;
  logic                     cmd_ready_i = 1'b1;
  logic [6:0]               cmd_funct7_o;
  logic [4:0]               cmd_rd_o;
  logic                     cmd_xd_o;
  logic [63:0]              cmd_rs1_o, cmd_rs2_o;
  logic                     resp_valid_i = 1'b0;
  logic                     resp_ready_o;
  logic [63:0]              resp_data_i = '0;
  logic                     resp_error_i = 1'b0;
  logic [TRANS_ID_BITS-1:0] rocc_trans_id_o;
  logic [63:0]              rocc_result_o;
  exception_t               rocc_exception_o;
  logic                     rocc_wb_valid_o;

  rocc_unit #(.NR_OUTSTANDING(4)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .fu_data_i        (fu_data_i),
    .rocc_valid_i     (rocc_valid_i),
    .rocc_funct7_i    (rocc_funct7_i),
    .rocc_rd_i        (rocc_rd_i),
    .rocc_ready_o     (rocc_ready_o),
    .cmd_valid_o      (cmd_valid_o),
    .cmd_ready_i      (cmd_ready_i),
    .cmd_funct7_o     (cmd_funct7_o),
    .cmd_rd_o         (cmd_rd_o),
    .cmd_xd_o         (cmd_xd_o),
    .cmd_rs1_o        (cmd_rs1_o),
    .cmd_rs2_o        (cmd_rs2_o),
    .resp_valid_i     (resp_valid_i),
    .resp_ready_o     (resp_ready_o),
    .resp_data_i      (resp_data_i),
    .resp_error_i     (resp_error_i),
    .rocc_trans_id_o  (rocc_trans_id_o),
    .rocc_result_o    (rocc_result_o),
    .rocc_exception_o (rocc_exception_o),
    .rocc_wb_valid_o  (rocc_wb_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;
  int wb_cnt   = 0;

  // Count writeback strobes, sampled mid-cycle.
  always @(negedge clk_i) if (rocc_wb_valid_o) wb_cnt++;

  typedef struct {
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  tid;
    logic [63:0] resp;
    logic        err;
    logic [63:0] exp_result;
    logic        exp_exc;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present an operation, wait (bounded) for ready, and hold it for one edge.
  task automatic issue(input logic [6:0] f7, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] b, input logic [2:0] tid);
    int n = 0;
    rocc_funct7_i = f7;
    rocc_rd_i     = rd;
    fu_data_i     = '{operand_a: a, operand_b: b, trans_id: tid};
    rocc_valid_i  = 1'b1;
    #1;
    while (!rocc_ready_o && n < 50) begin
      tick();
      n++;
    end
    check("issue_accepted", rocc_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    rocc_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [63:0] data, input logic err);
    resp_valid_i = 1'b1;
    resp_data_i  = data;
    resp_error_i = err;
    tick();
    resp_valid_i = 1'b0;
    resp_error_i = 1'b0;
  endtask

  // Writeback is expected now, and must be gone one cycle later.
  task automatic check_wb(input logic [2:0] tid, input logic [63:0] result, input logic exc);
    check("wb_valid", rocc_wb_valid_o, 1'b1);
    check("wb_trans_id", rocc_trans_id_o, tid);
    check("wb_result", rocc_result_o, result);
    check("wb_exc_valid", rocc_exception_o.valid, exc);
    check("wb_exc_cause", rocc_exception_o.cause, exc ? 64'd2 : 64'd0);
    check("wb_exc_tval", rocc_exception_o.tval, 64'd0);
    tick();
    check("wb_one_cycle", rocc_wb_valid_o, 1'b0);
  endtask

  initial begin
    int saved;
    vecs[0] = '{7'h01, 5'd5,  64'h10, 64'h20, 3'd3, 64'hABCD, 1'b0, 64'hABCD, 1'b0};
    vecs[1] = '{7'h02, 5'd0,  64'h11, 64'h22, 3'd2, 64'h0,    1'b0, 64'h0,    1'b0};
    vecs[2] = '{7'h7F, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd7,
                64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    vecs[3] = '{7'h11, 5'd1,  64'h33, 64'h44, 3'd0, 64'h1234, 1'b1, 64'h1234, 1'b1};
    vecs[4] = '{7'h00, 5'd0,  64'h55, 64'h66, 3'd5, 64'h0,    1'b0, 64'h0,    1'b0};

    // Reset values while reset is held.
    #1;
    check("rst_rocc_ready", rocc_ready_o, 1'b1);
    check("rst_resp_ready", resp_ready_o, 1'b1);
    check("rst_cmd_valid", cmd_valid_o, 1'b0);
    check("rst_cmd_rs1", cmd_rs1_o, 64'd0);
    check("rst_wb_valid", rocc_wb_valid_o, 1'b0);
    check("rst_wb_result", rocc_result_o, 64'd0);
    check("rst_wb_tid", rocc_trans_id_o, 3'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Table of single operations, cmd_ready_i held high.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].funct7, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].tid);
      check("cmd_valid", cmd_valid_o, 1'b1);
      check("cmd_funct7", cmd_funct7_o, vecs[i].funct7);
      check("cmd_rd", cmd_rd_o, vecs[i].rd);
      check("cmd_xd", cmd_xd_o, vecs[i].rd != 5'd0);
      check("cmd_rs1", cmd_rs1_o, vecs[i].rs1);
      check("cmd_rs2", cmd_rs2_o, vecs[i].rs2);
      tick();
      check("cmd_handed_off", cmd_valid_o, 1'b0);
      check("wb_not_yet", rocc_wb_valid_o, 1'b0);
      if (vecs[i].rd == 5'd0) begin
        check("resp_ready_xd0_head", resp_ready_o, 1'b0);
        tick();
      end else begin
        check("resp_ready_xd1_head", resp_ready_o, 1'b1);
        tick();
        check("wb_waits_resp", rocc_wb_valid_o, 1'b0);
        respond(vecs[i].resp, vecs[i].err);
      end
      check_wb(vecs[i].tid, vecs[i].exp_result, vecs[i].exp_exc);
    end

    // Backpressure: three ops queued, the fourth held in the command register.
    issue(7'h21, 5'd1, 64'h100, 64'h200, 3'd1);
    issue(7'h22, 5'd2, 64'h101, 64'h201, 3'd2);
    issue(7'h23, 5'd3, 64'h102, 64'h202, 3'd3);
    tick();
    check("bp_ready_three_queued", rocc_ready_o, 1'b1);
    cmd_ready_i = 1'b0;
    issue(7'h44, 5'd9, 64'h4444, 64'h8888, 3'd4);
    for (int k = 0; k < 3; k++) begin
      check("bp_cmd_held", cmd_valid_o, 1'b1);
      check("bp_cmd_funct7_stable", cmd_funct7_o, 7'h44);
      check("bp_cmd_rs1_stable", cmd_rs1_o, 64'h4444);
      check("bp_ready_low", rocc_ready_o, 1'b0);
      tick();
    end
    cmd_ready_i = 1'b1;
    tick();
    check("bp_ready_fifo_full", rocc_ready_o, 1'b0);
    check("bp_cmd_sent", cmd_valid_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      respond(64'h1000 + 64'(k), 1'b0);
      check_wb(3'(k + 1), 64'h1000 + 64'(k), 1'b0);
    end

    // Flush with three responses owed; a new op must not take a stale response.
    issue(7'h31, 5'd4, 64'h1, 64'h2, 3'd1);
    issue(7'h32, 5'd4, 64'h3, 64'h4, 3'd2);
    issue(7'h33, 5'd4, 64'h5, 64'h6, 3'd3);
    tick();
    flush_i = 1'b1;
    #1;
    check("flush_ready_low", rocc_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    check("flush_resp_ready", resp_ready_o, 1'b1);
    issue(7'h35, 5'd4, 64'h66, 64'h77, 3'd6);
    tick();
    check("drain_resp_ready", resp_ready_o, 1'b1);
    saved = wb_cnt;
    resp_valid_i = 1'b1;
    resp_data_i  = 64'hBAD;
    repeat (3) tick();
    resp_valid_i = 1'b0;
    tick();
    check("drain_no_wb", 64'(wb_cnt), 64'(saved));
    check("drain_wb_low", rocc_wb_valid_o, 1'b0);
    respond(64'h55, 1'b0);
    check_wb(3'd6, 64'h55, 1'b0);

    // Reset with two ops queued and one stuck in the command register.
    issue(7'h41, 5'd3, 64'h9, 64'hA, 3'd1);
    issue(7'h42, 5'd3, 64'hB, 64'hC, 3'd2);
    tick();
    cmd_ready_i = 1'b0;
    issue(7'h43, 5'd3, 64'hD, 64'hE, 3'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_cmd_valid", cmd_valid_o, 1'b0);
    check("mid_rst_cmd_funct7", cmd_funct7_o, 7'h00);
    check("mid_rst_rocc_ready", rocc_ready_o, 1'b1);
    check("mid_rst_resp_ready", resp_ready_o, 1'b1);
    check("mid_rst_wb_valid", rocc_wb_valid_o, 1'b0);
    cmd_ready_i = 1'b1;
    saved = wb_cnt;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) tick();
    check("post_rst_no_wb", 64'(wb_cnt), 64'(saved));
    check("post_rst_cmd_idle", cmd_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rocc_unit.md
Name: rocc_unit

Overview:
- Execute-side responder for the RoCC dispatch path: accepts operations issued with rocc_valid_i, rocc_funct7_i and rocc_rd_i plus fu_data_i.
- Forwards each operation as a command to an external accelerator over a valid/ready channel.
- Tracks outstanding operations in order and returns results on one scoreboard writeback port (trans_id, result, exception, valid).
- Sits in the execute stage beside the FPU and LSU; its writeback feeds one of the NR_WB_PORTS lanes.

Parameters:
- NR_OUTSTANDING, 4: depth of the in-order pending-operation FIFO; must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  squash every in-flight operation.
- fu_data_i  in  fu_data_t  operand_a = rs1 value, operand_b = rs2 value, trans_id = scoreboard tag.
- rocc_valid_i  in  1  issue strobe.
- rocc_funct7_i  in  7  funct7 field of the instruction.
- rocc_rd_i  in  5  destination register; 0 means no response is expected.
- rocc_ready_o  out  1  unit can accept an issue this cycle.
- cmd_valid_o  out  1  command to the accelerator is valid.
- cmd_ready_i  in  1  accelerator accepts the command.
- cmd_funct7_o  out  7  registered funct7.
- cmd_rd_o  out  5  registered rd.
- cmd_xd_o  out  1  response expected (rd != 0).
- cmd_rs1_o  out  64  registered operand_a.
- cmd_rs2_o  out  64  registered operand_b.
- resp_valid_i  in  1  accelerator response is valid.
- resp_ready_o  out  1  unit accepts the response.
- resp_data_i  in  64  response result.
- resp_error_i  in  1  accelerator reports a fault.
- rocc_trans_id_o  out  TRANS_ID_BITS  writeback tag.
- rocc_result_o  out  64  writeback data.
- rocc_exception_o  out  exception_t  writeback exception.
- rocc_wb_valid_o  out  1  writeback strobe, one cycle per operation.

Behaviour:
- Reset: the command register is empty, the FIFO is empty and drop_cnt is 0.
- All outputs reset to 0, except rocc_ready_o = 1 and resp_ready_o = 1 (FIFO empty, so a stray response is consumed).
- Command register (one entry):
  - Loaded on rocc_valid_i && rocc_ready_o.
  - cmd_valid_o is asserted from the next cycle and held until cmd_ready_i is seen; command fields stay stable while cmd_valid_o is high.
  - Minimum latency from issue to command is 1 cycle.
- rocc_ready_o = command register empty && (FIFO count + command occupancy) < NR_OUTSTANDING && !flush_i.
- Command handshake pushes {trans_id, xd} into the FIFO.
  - A command may be loaded into the register in the same cycle the previous one hands off.
  - The FIFO never overflows, because the check above reserves the slot.
- Retire, at most one per cycle, always from the FIFO head in order:
  - Head xd = 0: retire immediately. rocc_wb_valid_o = 1, result 0, exception.valid 0.
  - Head xd = 1: resp_ready_o = 1. On resp_valid_i, retire with rocc_result_o = resp_data_i.
  - If resp_error_i is set on retire: exception.valid = 1, cause = ILLEGAL_INSTR, tval = 0.
  - Writeback outputs are registered: valid 1 cycle after the retire condition, and low in all other cycles.
- A push and a pop in the same cycle are legal. Pointers wrap modulo NR_OUTSTANDING.
- Flush (flush_i = 1):
  - The command register is cleared. If a command handshake occurs in the flush cycle, that command counts as sent.
  - FIFO entries are discarded; every discarded entry with xd = 1 adds 1 to drop_cnt, as does a command sent in the flush cycle with xd = 1.
  - A writeback pending for the flush cycle is suppressed.
- Draining:
  - While drop_cnt != 0, resp_ready_o = 1 and each response decrements drop_cnt with no writeback.
  - The first response after a flush always goes to the drop path before any FIFO head.
- Responses with the FIFO empty and drop_cnt = 0 are consumed and ignored. A simulation assertion flags this case.
- drop_cnt is $clog2(NR_OUTSTANDING+1)+1 bits wide and saturation is not expected.
- Reset mid-operation: all state is cleared asynchronously; no writeback is emitted.

Decomposition:
- Shared package (ariane_pkg), existing: fu_data_t, exception_t, TRANS_ID_BITS, riscv::ILLEGAL_INSTR.
- New in the package: rocc_cmd_t {funct7, rd, xd, rs1, rs2} and rocc_resp_t {data, error}.
- One natural sub-module: rocc_pending_fifo, a generic in-order {trans_id, xd} FIFO with flush and an xd-count output used to load drop_cnt.

Test Plan:
- Issue rd=5, funct7=0x01, rs1=0x10, rs2=0x20, trans_id=3, cmd_ready_i=1. Response 0xABCD two cycles later. -> Command fields match; writeback trans_id=3, result=0xABCD, one cycle only.
- Issue rd=0, trans_id=2. -> After the command handshake, writeback trans_id=2, result=0 with no response needed; resp_ready_o stays 0 while the FIFO head has xd=0 and drop_cnt = 0.
- Hold cmd_ready_i=0 and issue 4 ops. -> rocc_ready_o deasserts after 4 are accepted (1 in the register + 3 ...); the command stays stable; releasing cmd_ready_i drains in order, and responses return in trans_id order.
- Three xd ops outstanding, then flush_i, then 3 responses, then a new op with response 0x55. -> No writeback for the 3 stale responses; the new op writes back 0x55 with its own trans_id.
- Response with resp_error_i=1. -> exception.valid=1, cause=ILLEGAL_INSTR, correct trans_id.
- Assert rst_ni low with 2 ops pending. -> Outputs return to reset values immediately; no writeback after reset is released.
